// File: rtl/bcd_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Shared constants and helpers for the sequential binary-to-BCD converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Decimal digit to 10-bit one-hot; non-decimal codes decode to all zeros.
    function automatic logic [9:0] onehot10(input logic [3:0] d);
        logic [9:0] r;
        r = 10'b0;
        if (d <= 4'd9) begin
            r[d] = 1'b1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module : bcd_digit_adj
// Single-nibble double-dabble correction: add 3 when the digit is 5 or more.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'(BCD_ADJ_THRESH)) ? (i_nib + 4'(BCD_ADJ_ADD)) : i_nib;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module : bin2bcd_seq
// Sequential shift-add-3 binary-to-BCD converter, one shift per clock.
// Optional: define BIN2BCD_ONEHOT_EN to add the registered digit_onehot output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
`ifdef BIN2BCD_ONEHOT_EN
    ,
    output logic [10*DIGITS-1:0]  digit_onehot
`endif
);

    localparam int CNT_W = clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    logic               r_state;
    logic               w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_bcd_shift;
    logic               r_ovf_acc;
    logic               w_ovf_next;
    logic               w_accept;
    logic               w_last;
    logic [BCD_W-1:0]   r_bcd_out;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_nib (r_bcd[4*g +: 4]),
                .o_nib (w_adj[4*g +: 4])
            );
        end
    endgenerate

    // The bit leaving the top adjusted nibble is a carry past the last digit.
    assign w_bcd_shift = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
    assign w_ovf_next  = r_ovf_acc | w_adj[BCD_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last) w_state_nxt = ST_IDLE;
            default:              w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept = (r_state == ST_IDLE) && start;
        w_last   = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(BIN_W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_ovf_acc <= 1'b0;
            r_bcd_out <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_bin     <= bin_in;
                r_bcd     <= '0;
                r_ovf_acc <= 1'b0;
                r_cnt     <= '0;
                r_busy    <= 1'b1;
            end else if (r_state == ST_SHIFT) begin
                r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
                r_bcd     <= w_bcd_shift;
                r_ovf_acc <= w_ovf_next;
                r_cnt     <= r_cnt + 1'b1;
                if (w_last) begin
                    r_bcd_out <= w_bcd_shift;
                    r_ovf     <= w_ovf_next;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd_out;
    assign ovf     = r_ovf;

`ifdef BIN2BCD_ONEHOT_EN
    logic [10*DIGITS-1:0] r_onehot;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_onehot
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_onehot[10*g +: 10] <= 10'b0000000001;
                end else if (w_last) begin
                    r_onehot[10*g +: 10] <= onehot10(w_bcd_shift[4*g +: 4]);
                end
            end
        end
    endgenerate

    assign digit_onehot = r_onehot;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
// Module : tb_bin2bcd_seq
// Scoreboard bench for bin2bcd_seq at 16/5 and 8/2 configurations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq;

    localparam int W1 = 16;
    localparam int D1 = 5;
    localparam int W2 = 8;
    localparam int D2 = 2;

    typedef struct {
        logic [4*D1-1:0] bcd;
        logic            ovf;
        int              due;
    } exp_a_t;

    typedef struct {
        logic [4*D2-1:0] bcd;
        logic            ovf;
        int              due;
    } exp_b_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_a = 1'b0;
    logic [W1-1:0]     bin_a = '0;
    logic              busy_a, done_a, ovf_a;
    logic [4*D1-1:0]   bcd_a;
    logic              start_b = 1'b0;
    logic [W2-1:0]     bin_b = '0;
    logic              busy_b, done_b, ovf_b;
    logic [4*D2-1:0]   bcd_b;
`ifdef BIN2BCD_ONEHOT_EN
    logic [10*D1-1:0]  oh_a;
    logic [10*D2-1:0]  oh_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int len_a    = 0;
    int len_b    = 0;
    exp_a_t q_a[$];
    exp_b_t q_b[$];

    bin2bcd_seq #(.BIN_W(W1), .DIGITS(D1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .ovf(ovf_a)
`ifdef BIN2BCD_ONEHOT_EN
        , .digit_onehot(oh_a)
`endif
    );

    bin2bcd_seq #(.BIN_W(W2), .DIGITS(D2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .ovf(ovf_b)
`ifdef BIN2BCD_ONEHOT_EN
        , .digit_onehot(oh_b)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint pow10(input int d);
        longint r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    // Reference: decimal digits of the value modulo 10^d, packed nibble-wise.
    function automatic logic [63:0] ref_bcd(input longint v, input int d);
        logic [63:0] r = '0;
        longint x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_onehot(input logic [63:0] bcd, input int d);
        logic [63:0] r = '0;
        for (int i = 0; i < d; i++) r[10*i + int'(bcd[4*i +: 4])] = 1'b1;
        return r;
    endfunction

    task automatic issue_a(input logic [W1-1:0] v);
        exp_a_t e;
        int t = 0;
        while (busy_a && t < 200) begin @(posedge clk); #1; t++; end
        chk("a_idle_wait", 64'(busy_a), 64'd0);
        start_a = 1'b1;
        bin_a   = v;
        e.bcd   = (4*D1)'(ref_bcd(longint'(v), D1));
        e.ovf   = (longint'(v) >= pow10(D1));
        e.due   = cyc + 1 + W1;
        q_a.push_back(e);
        @(posedge clk); #1;
        start_a = 1'b0;
        bin_a   = ~v;
        chk("a_busy_after_accept", 64'(busy_a), 64'd1);
    endtask

    task automatic issue_b(input logic [W2-1:0] v);
        exp_b_t e;
        int t = 0;
        while (busy_b && t < 200) begin @(posedge clk); #1; t++; end
        chk("b_idle_wait", 64'(busy_b), 64'd0);
        start_b = 1'b1;
        bin_b   = v;
        e.bcd   = (4*D2)'(ref_bcd(longint'(v), D2));
        e.ovf   = (longint'(v) >= pow10(D2));
        e.due   = cyc + 1 + W2;
        q_b.push_back(e);
        @(posedge clk); #1;
        start_b = 1'b0;
        bin_b   = ~v;
    endtask

    always @(negedge clk) begin
        exp_a_t e;
        if (rst) begin
            len_a = 0;
        end else begin
            if (busy_a) len_a++;
            else if (len_a != 0) begin chk("a_busy_len", 64'(len_a), 64'(W1)); len_a = 0; end
            if (done_a) begin
                if (q_a.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL a_spurious_done: got done=1 expected no pending job (t=%0t)", $time);
                end else begin
                    e = q_a.pop_front();
                    chk("a_bcd", 64'(bcd_a), 64'(e.bcd));
                    chk("a_ovf", 64'(ovf_a), 64'(e.ovf));
                    chk("a_latency", 64'(cyc), 64'(e.due));
`ifdef BIN2BCD_ONEHOT_EN
                    chk("a_onehot", 64'(oh_a), ref_onehot(64'(e.bcd), D1));
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_b_t e;
        if (rst) begin
            len_b = 0;
        end else begin
            if (busy_b) len_b++;
            else if (len_b != 0) begin chk("b_busy_len", 64'(len_b), 64'(W2)); len_b = 0; end
            if (done_b) begin
                if (q_b.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL b_spurious_done: got done=1 expected no pending job (t=%0t)", $time);
                end else begin
                    e = q_b.pop_front();
                    chk("b_bcd", 64'(bcd_b), 64'(e.bcd));
                    chk("b_ovf", 64'(ovf_b), 64'(e.ovf));
                    chk("b_latency", 64'(cyc), 64'(e.due));
`ifdef BIN2BCD_ONEHOT_EN
                    chk("b_onehot", 64'(oh_b), ref_onehot(64'(e.bcd), D2));
`endif
                end
            end
        end
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_bcd", 64'(bcd_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
`ifdef BIN2BCD_ONEHOT_EN
        chk("rst_onehot", 64'(oh_a), ref_onehot(64'd0, D1));
`endif

        issue_a(16'd1234);
        issue_a(16'd65535);
        issue_a(16'd0);

        // start while busy must be ignored
        issue_a(16'd500);
        repeat (4) @(posedge clk);
        #1 start_a = 1'b1; bin_a = 16'd777;
        @(posedge clk); #1 start_a = 1'b0;

        issue_a(16'd905);
        issue_a(16'd10000);

        // abort a conversion with reset after 7 cycles
        issue_a(16'd3000);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        q_a.delete();
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_busy", 64'(busy_a), 64'd0);
        chk("abort_done", 64'(done_a), 64'd0);
        chk("abort_bcd", 64'(bcd_a), 64'd0);
        chk("abort_ovf", 64'(ovf_a), 64'd0);
        repeat (W1 + 4) @(posedge clk);
        #1;
        issue_a(16'd42);

        for (int i = 0; i < 20; i++) issue_a(W1'($urandom_range(0, 65535)));

        issue_b(8'd99);
        issue_b(8'd255);
        issue_b(8'd100);
        issue_b(8'd0);
        for (int i = 0; i < 20; i++) issue_b(W2'($urandom_range(0, 255)));

        t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 500) begin @(posedge clk); t++; end
        #1;
        chk("drain_a", 64'(q_a.size()), 64'd0);
        chk("drain_b", 64'(q_b.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
